// File: rtl/beam_scan_controller.sv
// Direction-of-arrival scan sequencer: steps delay_select through every steering
// direction, integrates |beam sum| per direction, then locks onto the loudest one.
module beam_scan_controller #(
    parameter int NUM_DIRS      = 32,
    parameter int SETTLE_FRAMES = 16,
    parameter int DWELL_FRAMES  = 256,
    parameter int DATA_W        = 23,
    parameter int ACC_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lr_clk,
    input  logic [DATA_W-1:0] sum_in,
    input  logic              scan_en,
    input  logic              rescan,
    input  logic [4:0]        manual_sel,
    output logic [4:0]        delay_select,
    output logic [4:0]        best_dir,
    output logic [ACC_W-1:0]  best_energy,
    output logic              busy,
    output logic              scan_done
);

    typedef enum logic [2:0] {IDLE, SETTLE, DWELL, EVAL, LOCK} state_t;

    localparam int MAX_FRAMES = (SETTLE_FRAMES > DWELL_FRAMES) ? SETTLE_FRAMES : DWELL_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

    state_t             state_reg, state_next;
    logic               lr_q_reg;
    logic [4:0]         dir_reg, dir_next;
    logic [CNT_W-1:0]   frame_cnt_reg, frame_cnt_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [4:0]         best_dir_reg, best_dir_next;
    logic [ACC_W-1:0]   best_energy_reg, best_energy_next;
    logic [4:0]         delay_select_reg, delay_select_next;

    logic               tick;
    logic [DATA_W-1:0]  abs_val;
    logic [ACC_W:0]     acc_sum;

    assign tick = lr_clk & ~lr_q_reg;

    // Two's-complement negate as unsigned: the most-negative input maps to 2^(DATA_W-1) exactly.
    assign abs_val = sum_in[DATA_W-1] ? (~sum_in + DATA_W'(1)) : sum_in;
    assign acc_sum = {1'b0, acc_reg} + {{(ACC_W + 1 - DATA_W){1'b0}}, abs_val};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            lr_q_reg         <= 1'b0;
            dir_reg          <= '0;
            frame_cnt_reg    <= '0;
            acc_reg          <= '0;
            best_dir_reg     <= '0;
            best_energy_reg  <= '0;
            delay_select_reg <= '0;
        end else begin
            state_reg        <= state_next;
            lr_q_reg         <= lr_clk;
            dir_reg          <= dir_next;
            frame_cnt_reg    <= frame_cnt_next;
            acc_reg          <= acc_next;
            best_dir_reg     <= best_dir_next;
            best_energy_reg  <= best_energy_next;
            delay_select_reg <= delay_select_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        dir_next          = dir_reg;
        frame_cnt_next    = frame_cnt_reg;
        acc_next          = acc_reg;
        best_dir_next     = best_dir_reg;
        best_energy_next  = best_energy_reg;
        delay_select_next = delay_select_reg;

        // Dropping scan_en aborts from anywhere and outranks rescan; best result is kept.
        if (state_reg != IDLE && !scan_en) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    delay_select_next = manual_sel;
                    if (scan_en) begin
                        dir_next         = '0;
                        frame_cnt_next   = '0;
                        best_dir_next    = '0;
                        best_energy_next = '0;
                        state_next       = SETTLE;
                    end
                end
                SETTLE: begin
                    delay_select_next = dir_reg;
                    if (tick) begin
                        if (frame_cnt_reg == CNT_W'(SETTLE_FRAMES - 1)) begin
                            frame_cnt_next = '0;
                            acc_next       = '0;
                            state_next     = DWELL;
                        end else begin
                            frame_cnt_next = frame_cnt_reg + CNT_W'(1);
                        end
                    end
                end
                DWELL: begin
                    if (tick) begin
                        acc_next = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
                        if (frame_cnt_reg == CNT_W'(DWELL_FRAMES - 1)) begin
                            state_next = EVAL;
                        end else begin
                            frame_cnt_next = frame_cnt_reg + CNT_W'(1);
                        end
                    end
                end
                EVAL: begin
                    // Strict compare so ties stay with the lower index.
                    if (acc_reg > best_energy_reg || dir_reg == 5'd0) begin
                        best_energy_next = acc_reg;
                        best_dir_next    = dir_reg;
                    end
                    if (dir_reg == 5'(NUM_DIRS - 1)) begin
                        state_next = LOCK;
                    end else begin
                        dir_next       = dir_reg + 5'd1;
                        frame_cnt_next = '0;
                        state_next     = SETTLE;
                    end
                end
                LOCK: begin
                    delay_select_next = best_dir_reg;
                    if (rescan) begin
                        dir_next         = '0;
                        frame_cnt_next   = '0;
                        best_dir_next    = '0;
                        best_energy_next = '0;
                        state_next       = SETTLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign delay_select = delay_select_reg;
    assign best_dir     = best_dir_reg;
    assign best_energy  = best_energy_reg;
    assign busy         = (state_reg == SETTLE) || (state_reg == DWELL) || (state_reg == EVAL);
    assign scan_done    = (state_reg == LOCK);

endmodule

// File: tb/tb_beam_scan_controller.sv
// Directed bench for beam_scan_controller: table of scan patterns with hand-computed
// winners, plus sequences for abort, reset mid-scan and accumulator saturation.
module tb_beam_scan_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lr_clk = 1'b0;
    logic [22:0] sum_in;
    logic        scan_en = 1'b0;
    logic        rescan = 1'b0;
    logic [4:0]  manual_sel = 5'd0;
    logic [4:0]  delay_select;
    logic [4:0]  best_dir;
    logic [31:0] best_energy;
    logic        busy;
    logic        scan_done;

    logic [22:0] sum_in2;
    logic        scan_en2 = 1'b0;
    logic [4:0]  delay_select2;
    logic [4:0]  best_dir2;
    logic [23:0] best_energy2;
    logic        busy2;
    logic        scan_done2;

    logic [22:0] pat [4];

    int pass_cnt = 0;
    int total_cnt = 0;
    int seq [$];

    typedef struct {
        logic [22:0] p0, p1, p2, p3;
        logic [4:0]  exp_dir;
        logic [31:0] exp_energy;
    } vec_t;

    vec_t vecs [4];

    beam_scan_controller #(
        .NUM_DIRS(4), .SETTLE_FRAMES(2), .DWELL_FRAMES(4), .DATA_W(23), .ACC_W(32)
    ) dut (
        .clk(clk), .rst(rst), .lr_clk(lr_clk), .sum_in(sum_in), .scan_en(scan_en),
        .rescan(rescan), .manual_sel(manual_sel), .delay_select(delay_select),
        .best_dir(best_dir), .best_energy(best_energy), .busy(busy), .scan_done(scan_done)
    );

    beam_scan_controller #(
        .NUM_DIRS(2), .SETTLE_FRAMES(2), .DWELL_FRAMES(5), .DATA_W(23), .ACC_W(24)
    ) dut_sat (
        .clk(clk), .rst(rst), .lr_clk(lr_clk), .sum_in(sum_in2), .scan_en(scan_en2),
        .rescan(1'b0), .manual_sel(5'd0), .delay_select(delay_select2),
        .best_dir(best_dir2), .best_energy(best_energy2), .busy(busy2), .scan_done(scan_done2)
    );

    always #5 clk = ~clk;

    // Frame clock: period of 8 clk cycles, changing just after a clk edge.
    always begin
        repeat (4) @(posedge clk);
        #1 lr_clk = ~lr_clk;
    end

    always_comb sum_in = pat[delay_select[1:0]];
    assign sum_in2 = 23'd4194303;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            pass_cnt++;
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rescan();
        rescan = 1'b1;
        step();
        rescan = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        int last = -1;
        logic steps_ok;
        seq.delete();
        while (scan_done !== 1'b1 && n < 800) begin
            step();
            n++;
            if (busy && int'(delay_select) != last) begin
                last = int'(delay_select);
                seq.push_back(last);
            end
        end
        check({tag, " done_in_time"}, {31'd0, scan_done}, 32'd1);
        steps_ok = (seq.size() >= 4) && seq[seq.size()-4] == 0 && seq[seq.size()-3] == 1
                   && seq[seq.size()-2] == 2 && seq[seq.size()-1] == 3;
        check({tag, " steps_0123"}, {31'd0, steps_ok}, 32'd1);
    endtask

    task automatic wait_sel(input logic [4:0] v);
        int n = 0;
        while (delay_select !== v && n < 400) begin
            step();
            n++;
        end
        check("wait_delay_select", {27'd0, delay_select}, {27'd0, v});
    endtask

    initial begin
        vecs[0] = '{23'sd10, -23'sd300, 23'sd200, 23'sd0, 5'd1, 32'd1200};
        vecs[1] = '{23'h400000, 23'h400000, 23'h400000, 23'h400000, 5'd0, 32'd16777216};
        vecs[2] = '{23'sd5, 23'sd5, 23'sd5, 23'sd7, 5'd3, 32'd28};
        vecs[3] = '{23'sd7, -23'sd7, 23'sd7, -23'sd7, 5'd0, 32'd28};
        for (int i = 0; i < 4; i++) pat[i] = '0;

        repeat (3) step();
        rst = 1'b0;
        check("rst delay_select", {27'd0, delay_select}, 32'd0);
        check("rst best_dir", {27'd0, best_dir}, 32'd0);
        check("rst best_energy", best_energy, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst scan_done", {31'd0, scan_done}, 32'd0);

        manual_sel = 5'd9;
        step();
        check("manual delay_select", {27'd0, delay_select}, 32'd9);
        check("manual busy", {31'd0, busy}, 32'd0);
        check("manual scan_done", {31'd0, scan_done}, 32'd0);

        for (int v = 0; v < 4; v++) begin
            pat[0] = vecs[v].p0;
            pat[1] = vecs[v].p1;
            pat[2] = vecs[v].p2;
            pat[3] = vecs[v].p3;
            if (v == 0) begin
                scan_en = 1'b1;
                step();
            end else begin
                pulse_rescan();
            end
            wait_done($sformatf("vec%0d", v));
            step();
            $display("vec%0d: best_dir=%0d best_energy=%0d", v, best_dir, best_energy);
            check($sformatf("vec%0d best_dir", v), {27'd0, best_dir}, {27'd0, vecs[v].exp_dir});
            check($sformatf("vec%0d best_energy", v), best_energy, vecs[v].exp_energy);
            check($sformatf("vec%0d delay_select", v), {27'd0, delay_select}, {27'd0, vecs[v].exp_dir});
            check($sformatf("vec%0d busy", v), {31'd0, busy}, 32'd0);
        end

        // Abort during DWELL of dir 2, then restart from scratch.
        pat[0] = -23'sd1; pat[1] = 23'sd2; pat[2] = -23'sd3; pat[3] = 23'sd100;
        pulse_rescan();
        wait_sel(5'd2);
        repeat (20) step();
        scan_en = 1'b0;
        manual_sel = 5'd17;
        step();
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort scan_done", {31'd0, scan_done}, 32'd0);
        check("abort kept best_dir", {27'd0, best_dir}, 32'd1);
        check("abort kept best_energy", best_energy, 32'd8);
        step();
        check("abort manual delay_select", {27'd0, delay_select}, 32'd17);
        scan_en = 1'b1;
        step();
        check("restart busy", {31'd0, busy}, 32'd1);
        check("restart best_dir cleared", {27'd0, best_dir}, 32'd0);
        check("restart best_energy cleared", best_energy, 32'd0);
        wait_done("restart");
        check("restart best_dir", {27'd0, best_dir}, 32'd3);
        check("restart best_energy", best_energy, 32'd400);

        // Reset in the middle of SETTLE for dir 1.
        pulse_rescan();
        wait_sel(5'd1);
        repeat (2) step();
        check("pre-rst best_energy", best_energy, 32'd4);
        rst = 1'b1;
        scan_en = 1'b0;
        step();
        check("midrst delay_select", {27'd0, delay_select}, 32'd0);
        check("midrst best_dir", {27'd0, best_dir}, 32'd0);
        check("midrst best_energy", best_energy, 32'd0);
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst scan_done", {31'd0, scan_done}, 32'd0);
        rst = 1'b0;
        step();

        // 24-bit accumulator: 5 x 4194303 must clamp at 2^24-1.
        scan_en2 = 1'b1;
        begin
            int n = 0;
            while (scan_done2 !== 1'b1 && n < 800) begin
                step();
                n++;
            end
        end
        check("sat done_in_time", {31'd0, scan_done2}, 32'd1);
        check("sat best_energy", {8'd0, best_energy2}, 32'd16777215);
        check("sat best_dir", {27'd0, best_dir2}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/beam_scan_controller.md
Name: beam_scan_controller

Overview:
- Sequences the beamformer's `delay_select` input to perform a direction-of-arrival scan.
- Steps through every steering direction. At each direction it:
  - waits for the delay lines and CIC outputs to settle;
  - accumulates the magnitude of the summed beam output over a fixed number of audio frames.
- After the last direction it locks `delay_select` to the loudest direction.
- Sits beside the delay/adder/i2s chain: consumes the 23-bit adder sum, drives the 5-bit delay select.

Parameters:
- NUM_DIRS, 32, number of steering directions scanned (indices 0..NUM_DIRS-1, at most 32).
- SETTLE_FRAMES, 16, frames discarded after each `delay_select` change.
- DWELL_FRAMES, 256, frames accumulated per direction.
- DATA_W, 23, width of the signed beam sum input.
- ACC_W, 32, energy accumulator width (saturating).

Ports:
- clk  in  1  system clock, same clock as the datapath
- rst  in  1  synchronous, active-high reset
- lr_clk  in  1  frame clock, synchronous to clk; each rising edge is one frame
- sum_in  in  DATA_W  signed beam sum from the adder
- scan_en  in  1  1 = scan/lock mode, 0 = manual mode
- rescan  in  1  single-cycle pulse that restarts a scan while in LOCK
- manual_sel  in  5  delay select used in manual mode
- delay_select  out  5  registered steering index to the delay module
- best_dir  out  5  index of the loudest direction found so far
- best_energy  out  ACC_W  energy of best_dir
- busy  out  1  high in SETTLE/DWELL/EVAL
- scan_done  out  1  high in LOCK

Behaviour:
- Frame tick:
  - `lr_q` is `lr_clk` registered.
  - `tick = lr_clk & ~lr_q`.
  - `sum_in` is sampled on the tick cycle.
  - `lr_q` resets to 0.
- Reset values:
  - state = IDLE.
  - delay_select, best_dir, dir counter and frame counter = 0.
  - best_energy and acc = 0.
  - busy = 0, scan_done = 0.
- All outputs are registered. `busy` and `scan_done` are decoded from the registered state.
- IDLE:
  - `delay_select <= manual_sel` every cycle (one-cycle latency).
  - If scan_en = 1: dir <= 0, best_energy <= 0, best_dir <= 0, next state SETTLE.
- SETTLE:
  - `delay_select <= dir`.
  - Count ticks. After SETTLE_FRAMES ticks, clear acc and the frame counter, next state DWELL.
- DWELL:
  - On each tick: `acc <= sat(acc + |sum_in|)`.
  - `|x|` is DATA_W-bit unsigned. The most-negative value (-2^(DATA_W-1)) gives 2^(DATA_W-1) with no overflow.
  - `sat` clamps at 2^ACC_W-1.
  - The tick that completes DWELL_FRAMES is accumulated, and the next state is EVAL.
- EVAL (exactly one cycle):
  - If acc > best_energy (strictly), or dir == 0: best_energy <= acc, best_dir <= dir.
  - Ties keep the lower index.
  - If dir == NUM_DIRS-1: next state LOCK. Otherwise dir <= dir+1, next state SETTLE.
  - A tick arriving in EVAL is ignored.
- LOCK:
  - `delay_select <= best_dir`.
  - best_dir and best_energy are held.
  - rescan = 1: dir <= 0, best cleared, next state SETTLE.
- scan_en = 0 in any non-IDLE state: next cycle state = IDLE.
  - best_dir and best_energy retain their last values.
  - scan_en has priority over rescan.
- rescan outside LOCK is ignored.
- Reset asserted mid-scan returns all registers to reset values on the next clk edge.
- Scan duration is NUM_DIRS × (SETTLE_FRAMES + DWELL_FRAMES) frames plus NUM_DIRS clk cycles.

Test Plan (NUM_DIRS=4, SETTLE_FRAMES=2, DWELL_FRAMES=4, lr_clk period 8 clk):
- Reset then scan_en=0 with manual_sel=5'd9:
  - delay_select = 9 one cycle after manual_sel is applied.
  - busy = 0, scan_done = 0.
- Scan with sum_in driven per current delay_select as dir0 = +10, dir1 = -300, dir2 = +200, dir3 = 0:
  - delay_select steps 0→1→2→3.
  - Final state LOCK with best_dir = 1, best_energy = 1200, delay_select = 1, scan_done = 1.
- sum_in = -4194304 (DATA_W min) for all dirs:
  - acc per dir = 16777216.
  - Equal energies keep best_dir = 0.
- ACC_W=24 with sum_in = 4194303:
  - acc saturates at 16777215 and does not wrap.
- scan_en dropped during DWELL of dir 2:
  - IDLE next cycle, delay_select follows manual_sel, busy = 0.
  - scan_en reasserted → restart at dir 0 with best cleared.
- In LOCK, rescan pulse with new stimulus favouring dir 3:
  - Full rescan completes with best_dir = 3.
- rst pulsed mid-SETTLE:
  - All outputs return to 0 on the next edge.
